buffer_address_transmit: RTL

- Transmit-side counterpart of the host receive buffer path; turns queued buffer IDs back into 9-bit packet streams.
- Accepts buffer IDs (bufids) of stored packets, reads each packet word-by-word from packet RAM and emits it as a 9-bit stream with its bufid.
- Returns the bufid to the free pool after the tail word is emitted.
- Sits between the transmit scheduler (descriptor source) and the packet RAM / egress datapath.

---
 rtl/buffer_address_transmit.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/buffer_address_transmit.sv
`default_nettype none
// ============================================================================
// Module   : buffer_address_transmit
// Purpose  : Transmit-side buffer reader. Queues buffer IDs (bufids) of stored
//            packets, reads each packet word by word from packet RAM and emits
//            it as a 9-bit stream tagged with its bufid. After the tail word
//            has left, the bufid is handed back to the free pool.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_desc_wr            descriptor write strobe
//   iv_desc_bufid        bufid of the packet to transmit
//   o_desc_full          descriptor FIFO full (registered)
//   o_desc_overflow      one-cycle pulse: descriptor dropped, FIFO was full
//   o_ram_rd             packet RAM read strobe
//   ov_ram_raddr         read address {bufid, offset}
//   iv_ram_rdata         RAM word, valid RD_LAT cycles after o_ram_rd
//                        (bit8 = head/tail flag, [7:0] = byte)
//   ov_data, o_data_wr   output packet word and its valid
//   ov_bufid, o_bufid_wr bufid of the word on ov_data; strobe on the head word
//   ov_bufid_free        bufid returned to the free pool
//   o_bufid_free_wr      one-cycle release strobe
//   o_trunc_err          one-cycle pulse: buffer end reached with no tail
//   ov_tx_pkt_cnt        packets emitted, wrapping 16-bit count
// ============================================================================
module buffer_address_transmit #(
  parameter int OFF_W      = 11,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_desc_wr,
  input  logic [8:0]         iv_desc_bufid,
  output logic               o_desc_full,
  output logic               o_desc_overflow,
  output logic               o_ram_rd,
  output logic [9+OFF_W-1:0] ov_ram_raddr,
  input  logic [8:0]         iv_ram_rdata,
  output logic [8:0]         ov_data,
  output logic               o_data_wr,
  output logic [8:0]         ov_bufid,
  output logic               o_bufid_wr,
  output logic [8:0]         ov_bufid_free,
  output logic               o_bufid_free_wr,
  output logic               o_trunc_err,
  output logic [15:0]        ov_tx_pkt_cnt
);

  localparam int                 c_fifo_aw   = $clog2(FIFO_DEPTH);
  localparam logic [c_fifo_aw:0] c_fifo_full = FIFO_DEPTH[c_fifo_aw:0];
  localparam logic [c_fifo_aw:0] c_cnt_one   = 1;
  localparam logic [c_fifo_aw-1:0] c_ptr_one = 1;
  localparam logic [OFF_W-1:0]   c_off_max   = {OFF_W{1'b1}};
  localparam logic [OFF_W-1:0]   c_off_one   = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // descriptor FIFO
  logic [8:0]           r_fifo_mem [FIFO_DEPTH];
  logic [c_fifo_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_fifo_aw:0]   r_count, w_count_nxt;
  logic                 r_desc_full, r_desc_overflow;
  logic                 w_fifo_full, w_fifo_empty, w_push, w_pop;

  // packet sequencing
  state_t               r_state, w_state_nxt;
  logic [8:0]           r_bufid;
  logic [OFF_W-1:0]     r_offset;
  logic                 w_ram_rd;
  logic [RD_LAT-1:0]    r_vld;
  logic [OFF_W-1:0]     r_ret_idx;
  logic                 r_discard;
  logic                 w_emit, w_head, w_tail, w_trunc;

  // output registers
  logic [8:0]           r_data, r_out_bufid;
  logic                 r_data_wr, r_bufid_wr, r_trunc_err;
  logic [15:0]          r_pkt_cnt;

  // A write that meets a full FIFO is dropped even if IDLE pops in the same
  // cycle, so the decision uses the current count only.
  assign w_fifo_full  = (r_count == c_fifo_full);
  assign w_fifo_empty = (r_count == '0);
  assign w_push       = i_desc_wr & ~w_fifo_full;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= iv_desc_bufid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_desc_full     <= 1'b0;
      r_desc_overflow <= 1'b0;
    end else begin
      r_count         <= w_count_nxt;
      r_desc_full     <= (w_count_nxt == c_fifo_full);
      r_desc_overflow <= i_desc_wr & w_fifo_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Returned-word classification. Words arriving after the tail (or after
  // the truncated last word) come from over-issued reads and are dropped.
  assign w_emit  = r_vld[RD_LAT-1] & ~r_discard;
  assign w_head  = w_emit & (r_ret_idx == '0);
  assign w_tail  = w_emit & (r_ret_idx != '0) & iv_ram_rdata[8];
  assign w_trunc = w_emit & (r_ret_idx == c_off_max) & ~iv_ram_rdata[8];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_ram_rd    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        // the tail suppresses the read issued in its own cycle
        if (w_tail) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_ram_rd = 1'b1;
          if (r_offset == c_off_max) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_vld == '0) w_state_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_bufid   <= '0;
      r_offset  <= '0;
      r_ret_idx <= '0;
      r_discard <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_bufid  <= r_fifo_mem[r_rd_ptr];
        r_offset <= '0;
      end else if (w_ram_rd) begin
        r_offset <= r_offset + c_off_one;
      end
      if (w_pop) begin
        r_ret_idx <= '0;
        r_discard <= 1'b0;
      end else if (w_emit) begin
        r_ret_idx <= r_ret_idx + c_off_one;
        if (w_tail || w_trunc) r_discard <= 1'b1;
      end
      if (r_state == ST_RELEASE) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  // Read-valid pipeline: bit RD_LAT-1 marks the cycle iv_ram_rdata is valid.
  if (RD_LAT == 1) begin : g_vld_lat1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_vld <= '0;
      else          r_vld <= w_ram_rd;
    end
  end else begin : g_vld_latn
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_vld <= '0;
      else          r_vld <= {r_vld[RD_LAT-2:0], w_ram_rd};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data      <= '0;
      r_data_wr   <= 1'b0;
      r_out_bufid <= '0;
      r_bufid_wr  <= 1'b0;
      r_trunc_err <= 1'b0;
    end else begin
      r_data_wr   <= w_emit;
      r_bufid_wr  <= w_head;
      r_trunc_err <= w_trunc;
      r_out_bufid <= w_emit ? r_bufid : 9'd0;
      // head and truncated last word always leave with the flag set
      if (!w_emit)                r_data <= '0;
      else if (w_head || w_trunc) r_data <= {1'b1, iv_ram_rdata[7:0]};
      else                        r_data <= iv_ram_rdata;
    end
  end

  assign o_desc_full     = r_desc_full;
  assign o_desc_overflow = r_desc_overflow;
  assign o_ram_rd        = w_ram_rd;
  assign ov_ram_raddr    = w_ram_rd ? {r_bufid, r_offset} : '0;
  assign ov_data         = r_data;
  assign o_data_wr       = r_data_wr;
  assign ov_bufid        = r_out_bufid;
  assign o_bufid_wr      = r_bufid_wr;
  assign o_bufid_free_wr = (r_state == ST_RELEASE);
  assign ov_bufid_free   = (r_state == ST_RELEASE) ? r_bufid : 9'd0;
  assign o_trunc_err     = r_trunc_err;
  assign ov_tx_pkt_cnt   = r_pkt_cnt;

endmodule
`default_nettype wire
